// File: rtl/zynet_axil_pkg.sv
// Shared constants and types for the zyNet AXI4-Lite register slave.
package zynet_axil_pkg;

   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_ADDR_W = 5;

   // Register byte offsets; decode uses bits [4:2]
   localparam logic [AXI_ADDR_W-1:0] ADDR_WEIGHT = 5'h00;
   localparam logic [AXI_ADDR_W-1:0] ADDR_BIAS   = 5'h04;
   localparam logic [AXI_ADDR_W-1:0] ADDR_RESULT = 5'h08;
   localparam logic [AXI_ADDR_W-1:0] ADDR_LAYER  = 5'h0C;
   localparam logic [AXI_ADDR_W-1:0] ADDR_NEURON = 5'h10;
   localparam logic [AXI_ADDR_W-1:0] ADDR_NOUT   = 5'h14;
   localparam logic [AXI_ADDR_W-1:0] ADDR_STATUS = 5'h18;
   localparam logic [AXI_ADDR_W-1:0] ADDR_SRST   = 5'h1C;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Status register bit positions
   localparam int unsigned STAT_INTR = 0;
   localparam int unsigned STAT_FULL = 1;
   localparam int unsigned STAT_SRST = 2;
   localparam int unsigned STAT_W    = 3;

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

endpackage

// File: rtl/zynet_axil_slave_if.sv
// AXI4-Lite bus bundle between host master and the zyNet register slave.
interface zynet_axil_slave_if
   import zynet_axil_pkg::*;
#(
   parameter int unsigned ADDR_W = AXI_ADDR_W,
   parameter int unsigned DATA_W = AXI_DATA_W
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/zynet_out_buffer.sv
// Last-layer neuron output buffer: linear fill until full, wrapping readback.
module zynet_out_buffer #(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data_c,
   output logic             full_c
);
   localparam int unsigned WPW = $clog2(DEPTH + 1);
   localparam int unsigned RPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WPW-1:0]   wr_ptr;
   logic [RPW-1:0]   rd_ptr;
   logic             push_ok;

   assign full_c    = (wr_ptr == WPW'(DEPTH));
   assign rd_data_c = mem[rd_ptr];
   assign push_ok   = push && !full_c && !clr;

   // Pointer update; clear takes priority over push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + WPW'(1);
         if (pop)     rd_ptr <= (rd_ptr == RPW'(DEPTH - 1)) ? '0 : rd_ptr + RPW'(1);
      end
   end

   // Sample storage; contents survive a pointer clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[RPW'(wr_ptr)] <= push_data;
      end
   end
endmodule

// File: rtl/zynet_axil_slave.sv
// zyNet AXI4-Lite slave: weight/bias load strobes, config, result readback, interrupt.
module zynet_axil_slave
   import zynet_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned dataWidth          = 16,
   parameter int unsigned NUM_OUTPUTS        = 10
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   zynet_axil_slave_if.slave             axi,
   output logic                          weight_valid,
   output logic [C_S_AXI_DATA_WIDTH-1:0] weight_value,
   output logic                          bias_valid,
   output logic [C_S_AXI_DATA_WIDTH-1:0] bias_value,
   output logic [C_S_AXI_DATA_WIDTH-1:0] config_layer_num,
   output logic [C_S_AXI_DATA_WIDTH-1:0] config_neuron_num,
   output logic                          soft_reset,
   input  logic                          result_valid,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] result_digit,
   input  logic                          neuron_out_valid,
   input  logic [dataWidth-1:0]          neuron_out_data,
   output logic                          intr
);
   wr_state_e wr_state, wr_next;
   rd_state_e rd_state, rd_next;

   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [2:0]                    wr_sel, rd_sel;
   logic                          wr_fire, rd_fire;
   logic [C_S_AXI_DATA_WIDTH-1:0] result_reg, rdata_reg;
   logic [STAT_W-1:0]             status_c;
   logic [dataWidth-1:0]          nout_data_c;
   logic                          nout_full_c, nout_pop, nout_clr;
   logic                          unused_bits;

   assign wr_addr = axi.awaddr;
   assign rd_addr = axi.araddr;
   assign wr_sel  = 3'(wr_addr >> 2);
   assign rd_sel  = 3'(rd_addr >> 2);
   assign wr_fire = (wr_state == W_ACK);
   assign rd_fire = (rd_state == R_ACK);

   assign axi.awready = (wr_state == W_ACK);
   assign axi.wready  = (wr_state == W_ACK);
   assign axi.bvalid  = (wr_state == W_RESP);
   assign axi.bresp   = RESP_OKAY;
   assign axi.arready = (rd_state == R_ACK);
   assign axi.rvalid  = (rd_state == R_DATA);
   assign axi.rresp   = RESP_OKAY;
   assign axi.rdata   = rdata_reg;

   assign unused_bits = ^{axi.wstrb, wr_addr[1:0], rd_addr[1:0]};

   // Channel state registers
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   // Next state: idle -> one-cycle ready -> response held until accepted
   always_comb begin
      wr_next = wr_state;
      rd_next = rd_state;
      case (wr_state)
         W_IDLE:  if (axi.awvalid && axi.wvalid) wr_next = W_ACK;
         W_ACK:   wr_next = W_RESP;
         W_RESP:  if (axi.bready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
      case (rd_state)
         R_IDLE:  if (axi.arvalid) rd_next = R_ACK;
         R_ACK:   rd_next = R_DATA;
         R_DATA:  if (axi.rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // Write decode into strobes and config registers
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         weight_valid      <= 1'b0;
         weight_value      <= '0;
         bias_valid        <= 1'b0;
         bias_value        <= '0;
         config_layer_num  <= '0;
         config_neuron_num <= '0;
         soft_reset        <= 1'b1;
      end else begin
         weight_valid <= 1'b0;
         bias_valid   <= 1'b0;
         if (wr_fire) begin
            case (wr_sel)
               ADDR_WEIGHT[4:2]: begin
                  weight_value <= axi.wdata;
                  weight_valid <= 1'b1;
               end
               ADDR_BIAS[4:2]: begin
                  bias_value <= axi.wdata;
                  bias_valid <= 1'b1;
               end
               ADDR_LAYER[4:2]:  config_layer_num  <= axi.wdata;
               ADDR_NEURON[4:2]: config_neuron_num <= axi.wdata;
               ADDR_SRST[4:2]:   soft_reset        <= axi.wdata[0];
               default: ;
            endcase
         end
      end
   end

   // Result capture and interrupt; soft reset dominates, then a new result beats a clearing read
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         result_reg <= '0;
         intr       <= 1'b0;
      end else if (soft_reset) begin
         result_reg <= '0;
         intr       <= 1'b0;
      end else if (result_valid) begin
         result_reg <= result_digit;
         intr       <= 1'b1;
      end else if (rd_fire && rd_sel == ADDR_RESULT[4:2]) begin
         intr <= 1'b0;
      end
   end

   // Status word assembly
   always_comb begin
      status_c            = '0;
      status_c[STAT_INTR] = intr;
      status_c[STAT_FULL] = nout_full_c;
      status_c[STAT_SRST] = soft_reset;
   end

   // Read data captured in the address-accept cycle, held while rvalid waits
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rdata_reg <= '0;
      end else if (rd_fire) begin
         case (rd_sel)
            ADDR_RESULT[4:2]: rdata_reg <= result_reg;
            ADDR_LAYER[4:2]:  rdata_reg <= config_layer_num;
            ADDR_NEURON[4:2]: rdata_reg <= config_neuron_num;
            ADDR_NOUT[4:2]:   rdata_reg <= C_S_AXI_DATA_WIDTH'(nout_data_c);
            ADDR_STATUS[4:2]: rdata_reg <= C_S_AXI_DATA_WIDTH'(status_c);
            ADDR_SRST[4:2]:   rdata_reg <= C_S_AXI_DATA_WIDTH'(soft_reset);
            default:          rdata_reg <= '0;
         endcase
      end
   end

   assign nout_pop = rd_fire && (rd_sel == ADDR_NOUT[4:2]);
   assign nout_clr = soft_reset || result_valid;

   zynet_out_buffer #(
      .DEPTH (NUM_OUTPUTS),
      .WIDTH (dataWidth)
   ) u_out_buffer (
      .clk       (s_axi_aclk),
      .rst_n     (s_axi_aresetn),
      .clr       (nout_clr),
      .push      (neuron_out_valid),
      .push_data (neuron_out_data),
      .pop       (nout_pop),
      .rd_data_c (nout_data_c),
      .full_c    (nout_full_c)
   );
endmodule
